// File: rtl/mem_map_pkg.sv
// Shared definitions for the data-memory responder: I/O addresses and FSM states.
package mem_map_pkg;

  localparam logic [31:0] IO_BASE     = 32'h8000_0000;
  localparam logic [31:0] IO_LED_ADDR = IO_BASE;
  localparam logic [31:0] IO_CNT_ADDR = IO_BASE + 32'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port 32-bit RAM with synchronous write and synchronous, enabled read.
// The read register only updates when re is high, so it holds the last load result.
module sp_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Write and read ports share one address and act on the same edge.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts a request, waits WAIT_STATES cycles, commits the
// access on the edge entering RESP and pulses ready for one cycle. Decodes RAM,
// an LED register and a free-running cycle counter; other addresses set err.
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [7:0]  led,
  output logic        err
);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] cnt;
  logic [31:0] io_rdata;
  logic        rd_from_ram;
  logic [31:0] ram_q;

  logic        commit;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        is_ram;
  logic        is_led;
  logic        is_cnt;

  // With no wait states the access commits on its acceptance edge, so the live
  // inputs are used; otherwise the copies captured at acceptance are used.
  always_comb begin
    acc_we    = (state == IDLE) ? we    : we_q;
    acc_addr  = (state == IDLE) ? addr  : addr_q;
    acc_wdata = (state == IDLE) ? wdata : wdata_q;
    commit    = ((state == IDLE) && req && (WAIT_STATES == 0)) ||
                ((state == WAIT) && (wait_cnt == 4'd0));
    is_ram    = (acc_addr[31:ADDR_W] == '0);
    is_led    = (acc_addr == IO_LED_ADDR);
    is_cnt    = (acc_addr == IO_CNT_ADDR);
  end

  sp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (commit & acc_we & is_ram),
    .re    (commit & ~acc_we & is_ram),
    .addr  (acc_addr[ADDR_W-1:0]),
    .wdata (acc_wdata),
    .rdata (ram_q)
  );

  // Request FSM: accept in IDLE, count wait states, one RESP cycle, back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Commit-edge side effects: ready pulse, I/O register writes, load capture,
  // sticky error and the counter, where a counter store overrides the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready       <= 1'b0;
      led         <= 8'd0;
      err         <= 1'b0;
      cnt         <= 32'd0;
      io_rdata    <= 32'd0;
      rd_from_ram <= 1'b0;
    end else begin
      ready <= commit;
      if (commit && acc_we && is_cnt) cnt <= acc_wdata;
      else                            cnt <= cnt + 32'd1;
      if (commit) begin
        if (!(is_ram || is_led || is_cnt)) err <= 1'b1;
        if (acc_we) begin
          if (is_led) led <= acc_wdata[7:0];
        end else begin
          rd_from_ram <= is_ram;
          if (is_led)      io_rdata <= {24'd0, led};
          else if (is_cnt) io_rdata <= cnt;
          else             io_rdata <= 32'd0;
        end
      end
    end
  end

  assign rdata = rd_from_ram ? ram_q : io_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with two wait states, one with none,
// both compared against a behavioural model of memory, LED, error flag and counter.
module tb_data_mem_responder;
  import mem_map_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic [7:0]  led   [2];
  logic        err   [2];

  int ws [2];
  int edges = 0;
  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  logic [31:0] mem_m   [2][256];
  logic [7:0]  led_m   [2];
  logic        err_m   [2];
  logic [31:0] last_rd [2];
  logic [31:0] cnt_w   [2];
  int          cnt_n   [2];

  data_mem_responder #(.ADDR_W(8), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .led(led[0]), .err(err[0])
  );

  data_mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .led(led[1]), .err(err[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counter value held after edge number n
  function automatic logic [31:0] cnt_at(input int s, input int n);
    return cnt_w[s] + 32'(n - cnt_n[s]);
  endfunction

  // Applies one committed access to the model; last_rd holds the expected rdata.
  task automatic model_commit(input int s, input bit w, input logic [31:0] a,
                              input logic [31:0] d, input int ce);
    if (a < 32'd256) begin
      if (w) mem_m[s][a[7:0]] = d;
      else   last_rd[s] = mem_m[s][a[7:0]];
    end else if (a == IO_LED_ADDR) begin
      if (w) led_m[s] = d[7:0];
      else   last_rd[s] = {24'd0, led_m[s]};
    end else if (a == IO_CNT_ADDR) begin
      if (w) begin
        cnt_w[s] = d;
        cnt_n[s] = ce;
      end else begin
        last_rd[s] = cnt_at(s, ce - 1);
      end
    end else begin
      err_m[s] = 1'b1;
      if (!w) last_rd[s] = 32'd0;
    end
  endtask

  // Drives one request from a falling edge; reports latency from the first
  // possible acceptance edge, the commit edge, rdata in the ready cycle and
  // (when req is dropped) ready in the following cycle.
  task automatic drive(input int s, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit hold,
                       output int lat, output int ce, output logic [31:0] got,
                       output logic rdy_next);
    int e0;
    req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
    e0 = edges + 1;
    lat = -1;
    ce = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready[s]) begin
        lat = edges - e0;
        ce = edges;
        break;
      end
    end
    got = rdata[s];
    rdy_next = 1'b0;
    if (!hold || lat < 0) begin
      req[s] = 1'b0;
      @(negedge clk);
      rdy_next = ready[s];
    end
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; we[s] = 1'b0; addr[s] = 32'd0; wdata[s] = 32'd0;
    end
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      led_m[s] = 8'd0; err_m[s] = 1'b0; last_rd[s] = 32'd0;
      cnt_w[s] = 32'd0; cnt_n[s] = edges;
    end
  endtask

  task automatic test_reset();
    assert_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (ready[s] !== 1'b0) $display("[TB] FAIL reset_ready[%0d]: got %b required 0", s, ready[s]);
      else n_pass++;
      n_total++;
      if (rdata[s] !== 32'd0) $display("[TB] FAIL reset_rdata[%0d]: got %h required 0", s, rdata[s]);
      else n_pass++;
      n_total++;
      if (led[s] !== 8'd0) $display("[TB] FAIL reset_led[%0d]: got %h required 0", s, led[s]);
      else n_pass++;
      n_total++;
      if (err[s] !== 1'b0) $display("[TB] FAIL reset_err[%0d]: got %b required 0", s, err[s]);
      else n_pass++;
    end
    release_reset();
  endtask

  task automatic test_ram_store_load();
    int lat, ce; logic [31:0] got; logic rn;
    drive(0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0, lat, ce, got, rn);
    model_commit(0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, ce);
    n_total++;
    if (lat !== 2) $display("[TB] FAIL store_latency: got %0d required 2", lat);
    else n_pass++;
    drive(0, 1'b0, 32'h0000_0005, 32'd0, 1'b0, lat, ce, got, rn);
    model_commit(0, 1'b0, 32'h0000_0005, 32'd0, ce);
    n_total++;
    if (lat !== 2) $display("[TB] FAIL load_latency: got %0d required 2", lat);
    else n_pass++;
    n_total++;
    if (got !== 32'hDEAD_BEEF) $display("[TB] FAIL ram_load: got %h required deadbeef", got);
    else n_pass++;
    n_total++;
    if (rn !== 1'b0) $display("[TB] FAIL ready_width: got %b required 0", rn);
    else n_pass++;
  endtask

  task automatic test_led();
    int lat, ce; logic [31:0] got; logic rn;
    drive(0, 1'b1, IO_LED_ADDR, 32'h0000_01A5, 1'b0, lat, ce, got, rn);
    model_commit(0, 1'b1, IO_LED_ADDR, 32'h0000_01A5, ce);
    n_total++;
    if (led[0] !== 8'hA5) $display("[TB] FAIL led_value: got %h required a5", led[0]);
    else n_pass++;
    n_total++;
    if (got !== 32'hDEAD_BEEF) $display("[TB] FAIL store_keeps_rdata: got %h required deadbeef", got);
    else n_pass++;
    drive(0, 1'b0, IO_LED_ADDR, 32'd0, 1'b0, lat, ce, got, rn);
    model_commit(0, 1'b0, IO_LED_ADDR, 32'd0, ce);
    n_total++;
    if (got !== 32'h0000_00A5) $display("[TB] FAIL led_load: got %h required 000000a5", got);
    else n_pass++;
  endtask

  task automatic test_counter();
    int lat, ce; logic [31:0] got; logic rn;
    drive(1, 1'b1, IO_CNT_ADDR, 32'hFFFF_FFFE, 1'b1, lat, ce, got, rn);
    model_commit(1, 1'b1, IO_CNT_ADDR, 32'hFFFF_FFFE, ce);
    n_total++;
    if (lat !== 0) $display("[TB] FAIL ws0_latency: got %0d required 0", lat);
    else n_pass++;
    drive(1, 1'b0, IO_CNT_ADDR, 32'd0, 1'b0, lat, ce, got, rn);
    model_commit(1, 1'b0, IO_CNT_ADDR, 32'd0, ce);
    n_total++;
    if (got !== 32'hFFFF_FFFF) $display("[TB] FAIL cnt_immediate: got %h required ffffffff", got);
    else n_pass++;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    drive(1, 1'b0, IO_CNT_ADDR, 32'd0, 1'b0, lat, ce, got, rn);
    model_commit(1, 1'b0, IO_CNT_ADDR, 32'd0, ce);
    n_total++;
    if (got !== last_rd[1]) $display("[TB] FAIL cnt_wrapped: got %h required %h", got, last_rd[1]);
    else n_pass++;
  endtask

  task automatic test_error();
    int lat, ce; logic [31:0] got; logic rn;
    drive(0, 1'b0, 32'h0000_1000, 32'd0, 1'b0, lat, ce, got, rn);
    model_commit(0, 1'b0, 32'h0000_1000, 32'd0, ce);
    n_total++;
    if (got !== 32'd0) $display("[TB] FAIL oob_rdata: got %h required 0", got);
    else n_pass++;
    n_total++;
    if (err[0] !== 1'b1) $display("[TB] FAIL oob_err: got %b required 1", err[0]);
    else n_pass++;
    drive(0, 1'b1, 32'h0000_0006, 32'h1234_5678, 1'b0, lat, ce, got, rn);
    model_commit(0, 1'b1, 32'h0000_0006, 32'h1234_5678, ce);
    n_total++;
    if (err[0] !== 1'b1) $display("[TB] FAIL err_sticky: got %b required 1", err[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat1, ce1, lat2, ce2; logic [31:0] got, v; logic rn;
    v = $urandom;
    drive(0, 1'b1, 32'h0000_0007, v, 1'b1, lat1, ce1, got, rn);
    model_commit(0, 1'b1, 32'h0000_0007, v, ce1);
    drive(0, 1'b0, 32'h0000_0007, 32'd0, 1'b0, lat2, ce2, got, rn);
    model_commit(0, 1'b0, 32'h0000_0007, 32'd0, ce2);
    n_total++;
    if (ce2 - ce1 !== 4) $display("[TB] FAIL b2b_spacing: got %0d required 4", ce2 - ce1);
    else n_pass++;
    n_total++;
    if (got !== v) $display("[TB] FAIL b2b_load: got %h required %h", got, v);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int lat, ce; logic [31:0] got, x; logic rn, saw_ready;
    x = $urandom;
    drive(0, 1'b1, 32'h0000_0003, x, 1'b0, lat, ce, got, rn);
    model_commit(0, 1'b1, 32'h0000_0003, x, ce);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_0003; wdata[0] = ~x;
    @(negedge clk);
    assert_reset();
    n_total++;
    if (led[0] !== 8'd0) $display("[TB] FAIL midwait_led: got %h required 0", led[0]);
    else n_pass++;
    n_total++;
    if (err[0] !== 1'b0) $display("[TB] FAIL midwait_err: got %b required 0", err[0]);
    else n_pass++;
    n_total++;
    if (rdata[0] !== 32'd0) $display("[TB] FAIL midwait_rdata: got %h required 0", rdata[0]);
    else n_pass++;
    saw_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready[0]) saw_ready = 1'b1;
    end
    n_total++;
    if (saw_ready !== 1'b0) $display("[TB] FAIL midwait_ready: got %b required 0", saw_ready);
    else n_pass++;
    release_reset();
    drive(0, 1'b0, 32'h0000_0003, 32'd0, 1'b0, lat, ce, got, rn);
    model_commit(0, 1'b0, 32'h0000_0003, 32'd0, ce);
    n_total++;
    if (lat !== 2) $display("[TB] FAIL post_reset_latency: got %0d required 2", lat);
    else n_pass++;
    n_total++;
    if (got !== x) $display("[TB] FAIL ram_unchanged: got %h required %h", got, x);
    else n_pass++;
    drive(0, 1'b0, IO_CNT_ADDR, 32'd0, 1'b0, lat, ce, got, rn);
    model_commit(0, 1'b0, IO_CNT_ADDR, 32'd0, ce);
    n_total++;
    if (got !== last_rd[0]) $display("[TB] FAIL cnt_after_reset: got %h required %h", got, last_rd[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, ce, s, kind; logic [31:0] a, d, got; logic w, rn;
    for (int k = 0; k < 16; k++) begin
      s = k / 8;
      d = $urandom;
      drive(s, 1'b1, 32'(k % 8), d, 1'b0, lat, ce, got, rn);
      model_commit(s, 1'b1, 32'(k % 8), d, ce);
    end
    for (int it = 0; it < 40; it++) begin
      s = $urandom_range(0, 1);
      kind = $urandom_range(0, 5);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (kind <= 2)      a = 32'($urandom_range(0, 7));
      else if (kind == 3) a = IO_LED_ADDR;
      else if (kind == 4) a = IO_CNT_ADDR;
      else                a = 32'h0000_0100 | $urandom;
      drive(s, w, a, d, 1'b0, lat, ce, got, rn);
      model_commit(s, w, a, d, ce);
      n_total++;
      if (lat !== ws[s]) $display("[TB] FAIL rnd_latency[%0d]: got %0d required %0d", it, lat, ws[s]);
      else n_pass++;
      n_total++;
      if (got !== last_rd[s]) $display("[TB] FAIL rnd_rdata[%0d] addr %h: got %h required %h", it, a, got, last_rd[s]);
      else n_pass++;
      n_total++;
      if (led[s] !== led_m[s]) $display("[TB] FAIL rnd_led[%0d]: got %h required %h", it, led[s], led_m[s]);
      else n_pass++;
      n_total++;
      if (err[s] !== err_m[s]) $display("[TB] FAIL rnd_err[%0d]: got %b required %b", it, err[s], err_m[s]);
      else n_pass++;
      n_total++;
      if (rn !== 1'b0) $display("[TB] FAIL rnd_ready_width[%0d]: got %b required 0", it, rn);
      else n_pass++;
    end
  endtask

  // Scenario sequence, then the summary line.
  initial begin
    ws[0] = 2;
    ws[1] = 0;
    test_reset();
    test_ram_store_load();
    test_led();
    test_counter();
    test_error();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
